flush_redirect_ctrl: RTL and testbench

//  Sequences pipeline recovery after the write-back stage raises a flush. Latches the flush cause and target PC,

---
 rtl/flush_redirect_ctrl.sv | 129 ++++++++++++
 tb/tb_flush_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/flush_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flush_redirect_ctrl : WB flush sequencer -> timed pipe_flush, optional   |
// |   CACOP/IDLE wait, then one valid/ready redirect to fetch.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module flush_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic        refetch_flush,
  input  logic        icacop_flush,
  input  logic        idle_flush,
  input  logic        excp_tlbrefill,
  input  logic [31:0] ws_pc,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_tlbrentry,
  input  logic [31:0] csr_era,
  input  logic        has_int,
  input  logic        icacop_done,
  input  logic        redirect_ready,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fetch_hold,
  output logic        idle_state,
  output logic        busy
);

  localparam logic [2:0] c_st_run   = 3'd0;
  localparam logic [2:0] c_st_flush = 3'd1;
  localparam logic [2:0] c_st_cacop = 3'd2;
  localparam logic [2:0] c_st_idle  = 3'd3;
  localparam logic [2:0] c_st_redir = 3'd4;

  localparam logic [1:0] c_cause_redir = 2'd0;
  localparam logic [1:0] c_cause_cacop = 2'd1;
  localparam logic [1:0] c_cause_idle  = 2'd2;

  localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES - 1);

  logic [2:0]  r_state;
  logic [1:0]  r_cause;
  logic [3:0]  r_cnt;
  logic [31:0] r_pc;
  logic        r_done_seen;
  logic        r_int_seen;

  logic        w_trig;
  logic [1:0]  w_cause;
  logic [31:0] w_target;

  function automatic logic [2:0] f_wait_state(input logic [1:0] cause);
    case (cause)
      c_cause_cacop: f_wait_state = c_st_cacop;
      c_cause_idle:  f_wait_state = c_st_idle;
      default:       f_wait_state = c_st_redir;
    endcase
  endfunction

  assign w_trig = excp_flush | ertn_flush | refetch_flush | icacop_flush | idle_flush;

  // Priority: excp > ertn > icacop > idle > refetch
  always_comb begin
    w_cause  = c_cause_redir;
    w_target = ws_pc + 32'd4;
    if (excp_flush) begin
      w_target = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
    end else if (ertn_flush) begin
      w_target = csr_era;
    end else if (icacop_flush) begin
      w_cause = c_cause_cacop;
    end else if (idle_flush) begin
      w_cause = c_cause_idle;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_st_run;
      r_cause     <= c_cause_redir;
      r_cnt       <= 4'd0;
      r_pc        <= 32'd0;
      r_done_seen <= 1'b0;
      r_int_seen  <= 1'b0;
    end else begin
      case (r_state)
        c_st_run: begin
          if (w_trig) begin
            r_cause     <= w_cause;
            r_pc        <= w_target;
            r_cnt       <= c_flush_init;
            r_done_seen <= 1'b0;
            r_int_seen  <= 1'b0;
            r_state     <= (FLUSH_CYCLES == 1) ? f_wait_state(w_cause) : c_st_flush;
          end
        end
        c_st_flush: begin
          // Wake-up events arriving while still flushing must not be lost
          r_cnt <= r_cnt - 4'd1;
          if (icacop_done) r_done_seen <= 1'b1;
          if (has_int)     r_int_seen  <= 1'b1;
          if (r_cnt <= 4'd1) r_state <= f_wait_state(r_cause);
        end
        c_st_cacop: begin
          if (icacop_done || r_done_seen) r_state <= c_st_redir;
        end
        c_st_idle: begin
          if (has_int || r_int_seen) r_state <= c_st_redir;
        end
        c_st_redir: begin
          if (redirect_ready) r_state <= c_st_run;
        end
        default: r_state <= c_st_run;
      endcase
    end
  end

  assign pipe_flush     = (r_state == c_st_flush) || ((r_state == c_st_run) && w_trig);
  assign fetch_hold     = (r_state == c_st_flush) || (r_state == c_st_cacop) || (r_state == c_st_idle);
  assign idle_state     = (r_state == c_st_idle);
  assign redirect_valid = (r_state == c_st_redir);
  assign redirect_pc    = r_pc;
  assign busy           = (r_state != c_st_run);

endmodule
`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flush_redirect_ctrl : directed self-checking bench. Rev 1.0           |
// +--------------------------------------------------------------------------+
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        excp_flush = 1'b0, ertn_flush = 1'b0, refetch_flush = 1'b0;
  logic        icacop_flush = 1'b0, idle_flush = 1'b0, excp_tlbrefill = 1'b0;
  logic [31:0] ws_pc = 32'd0, csr_eentry = 32'd0, csr_tlbrentry = 32'd0, csr_era = 32'd0;
  logic        has_int = 1'b0, icacop_done = 1'b0, redirect_ready = 1'b0;
  logic        pipe_flush, redirect_valid, fetch_hold, idle_state, busy;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  flush_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .refetch_flush(refetch_flush),
    .icacop_flush(icacop_flush), .idle_flush(idle_flush), .excp_tlbrefill(excp_tlbrefill),
    .ws_pc(ws_pc), .csr_eentry(csr_eentry), .csr_tlbrentry(csr_tlbrentry), .csr_era(csr_era),
    .has_int(has_int), .icacop_done(icacop_done), .redirect_ready(redirect_ready),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_hold(fetch_hold), .idle_state(idle_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pipe_flush"}, {31'd0, pipe_flush}, 32'd0);
    check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
    check({tag, "_fetch_hold"}, {31'd0, fetch_hold}, 32'd0);
    check({tag, "_idle_state"}, {31'd0, idle_state}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  // f = {excp, ertn, icacop, idle, refetch}; returns one cycle later (first FLUSH cycle)
  task automatic pulse_flush(input string tag, input logic [4:0] f);
    {excp_flush, ertn_flush, icacop_flush, idle_flush, refetch_flush} = f;
    #1;
    check({tag, "_trig_pipe_flush"}, {31'd0, pipe_flush}, 32'd1);
    check({tag, "_trig_busy"}, {31'd0, busy}, 32'd0);
    tick();
    {excp_flush, ertn_flush, icacop_flush, idle_flush, refetch_flush} = 5'b0;
    #1;
  endtask

  // Called in a FLUSH cycle; with ready=1, checks redirect next cycle and return to RUN
  task automatic finish_plain(input string tag, input logic [31:0] exp_pc);
    check({tag, "_flush_pipe_flush"}, {31'd0, pipe_flush}, 32'd1);
    check({tag, "_flush_hold"}, {31'd0, fetch_hold}, 32'd1);
    tick();
    check({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
    check({tag, "_pc"}, redirect_pc, exp_pc);
    check({tag, "_rv_pipe_flush"}, {31'd0, pipe_flush}, 32'd0);
    check({tag, "_rv_hold"}, {31'd0, fetch_hold}, 32'd0);
    tick();
    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_rv"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    redirect_ready = 1'b1;
    tick();

    // T1 refetch
    ws_pc = 32'h1C00_0100;
    pulse_flush("t1", 5'b00001);
    finish_plain("t1", 32'h1C00_0104);

    // T2 excp beats refetch; tlbrefill selects tlbrentry
    ws_pc = 32'h1C00_0300; csr_tlbrentry = 32'h1C00_F000; csr_eentry = 32'h1C00_E000;
    csr_era = 32'h1C00_2000; excp_tlbrefill = 1'b1;
    pulse_flush("t2a", 5'b10001);
    excp_tlbrefill = 1'b0;
    finish_plain("t2a", 32'h1C00_F000);
    pulse_flush("t2b", 5'b01000);
    finish_plain("t2b", 32'h1C00_2000);
    pulse_flush("t2c", 5'b11000);
    finish_plain("t2c", 32'h1C00_E000);

    // T3 icacop, done arrives in cycle 5 after trigger
    ws_pc = 32'h1C00_0400;
    pulse_flush("t3", 5'b00100);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) icacop_done = 1'b1;
      #1;
      check("t3_hold", {31'd0, fetch_hold}, 32'd1);
      check("t3_no_rv", {31'd0, redirect_valid}, 32'd0);
      check("t3_pipe_flush", {31'd0, pipe_flush}, (i == 1) ? 32'd1 : 32'd0);
      tick();
      icacop_done = 1'b0;
    end
    check("t3_rv", {31'd0, redirect_valid}, 32'd1);
    check("t3_pc", redirect_pc, 32'h1C00_0404);
    tick();
    check("t3_run", {31'd0, busy}, 32'd0);

    // T3b done during FLUSH: CACOP_WAIT exits in its first cycle
    pulse_flush("t3b", 5'b00100);
    icacop_done = 1'b1;
    tick();
    icacop_done = 1'b0;
    #1;
    check("t3b_wait_hold", {31'd0, fetch_hold}, 32'd1);
    check("t3b_wait_no_rv", {31'd0, redirect_valid}, 32'd0);
    tick();
    check("t3b_rv", {31'd0, redirect_valid}, 32'd1);
    check("t3b_pc", redirect_pc, 32'h1C00_0404);
    tick();
    check("t3b_run", {31'd0, busy}, 32'd0);

    // T4 idle with pc wrap; 20 cycles of idle_state
    ws_pc = 32'hFFFF_FFFC;
    pulse_flush("t4", 5'b00010);
    check("t4_flush_idle", {31'd0, idle_state}, 32'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 19) has_int = 1'b1;
      #1;
      check("t4_idle", {31'd0, idle_state}, 32'd1);
      check("t4_hold", {31'd0, fetch_hold}, 32'd1);
      tick();
      has_int = 1'b0;
    end
    check("t4_idle_off", {31'd0, idle_state}, 32'd0);
    check("t4_rv", {31'd0, redirect_valid}, 32'd1);
    check("t4_pc", redirect_pc, 32'h0000_0000);
    tick();

    // T4b has_int during FLUSH
    ws_pc = 32'h1C00_0500;
    pulse_flush("t4b", 5'b00010);
    has_int = 1'b1;
    tick();
    has_int = 1'b0;
    #1;
    check("t4b_idle", {31'd0, idle_state}, 32'd1);
    tick();
    check("t4b_rv", {31'd0, redirect_valid}, 32'd1);
    check("t4b_pc", redirect_pc, 32'h1C00_0504);
    tick();

    // T5 backpressure; excp pulse in REDIRECT ignored
    redirect_ready = 1'b0;
    ws_pc = 32'h1C00_0200; csr_eentry = 32'h1C00_E100;
    pulse_flush("t5", 5'b00001);
    tick();
    for (int j = 0; j < 4; j++) begin
      if (j == 1) excp_flush = 1'b1;
      if (j == 3) redirect_ready = 1'b1;
      #1;
      check("t5_rv", {31'd0, redirect_valid}, 32'd1);
      check("t5_pc", redirect_pc, 32'h1C00_0204);
      check("t5_no_flush", {31'd0, pipe_flush}, 32'd0);
      tick();
      excp_flush = 1'b0;
    end
    check("t5_rv_off", {31'd0, redirect_valid}, 32'd0);
    check("t5_run", {31'd0, busy}, 32'd0);
    // Back-to-back trigger right after the handshake
    pulse_flush("t5n", 5'b00001);
    finish_plain("t5n", 32'h1C00_0204);

    // T6 reset in IDLE_WAIT
    pulse_flush("t6a", 5'b00010);
    tick();
    check("t6a_idle", {31'd0, idle_state}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("t6a_rst");
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("t6a_run", {31'd0, busy}, 32'd0);
    check("t6a_no_rv", {31'd0, redirect_valid}, 32'd0);

    // T6 reset in REDIRECT
    redirect_ready = 1'b0;
    pulse_flush("t6b", 5'b00001);
    tick();
    check("t6b_rv", {31'd0, redirect_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("t6b_rst");
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    check("t6b_run", {31'd0, busy}, 32'd0);
    check("t6b_no_rv", {31'd0, redirect_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
